integrab_paging_unit: RTL and testbench
=======================================

INTEGRAB_PAGING_UNIT -- requirements
Module: integrab_paging_unit

Interface
REQ-001 SHALL have parameter BANK_BITS, default 4, giving the sideways bank number width; legal values are 4 and 5, so NUM_BANKS = 2^BANK_BITS.
REQ-002 SHALL have parameter UNLOCK_TIMEOUT, default 255, giving the clock cycles the write-protect unlock window stays open; legal range is 1..255.
REQ-003 from_CPU_Phi2  in  1  clock; one rising edge per CPU bus cycle; all state changes on the rising edge.
REQ-004 bbc_RST  in  1  reset; synchronous, active-high.
REQ-005 from_CPU_RnW  in  1  1 = read, 0 = write, for the cycle ending at this edge.
REQ-006 bbc_ADDRESS  in  16  CPU address.
REQ-007 bbc_DATA  in  8  CPU write data.
REQ-008 rom_bank  out  BANK_BITS  selected sideways bank.
REQ-009 prv_en, mem_sel, sh_en, prv_s1, prv_s4, prv_s8  out  1 each  paging control flags.
REQ-010 wr_prot  out  NUM_BANKS  per-bank write-protect; 1 = protected.
REQ-011 wp_locked  out  1  1 when the write-protect registers are locked.
REQ-012 cpu_dout  out  8  register readback data.
REQ-013 cpu_dout_oe  out  1  readback drive enable.

Function
REQ-014 Register writes SHALL occur only at an edge where from_CPU_RnW=0 and the full 16-bit bbc_ADDRESS matches a register address.
REQ-015 ROMSEL at &FE30 SHALL work as follows:
- rom_bank <= DATA[BANK_BITS-1:0]
- prv_en <= DATA[6]
- mem_sel <= DATA[7]
- with BANK_BITS=4, DATA[5:4] are ignored.
REQ-016 ACCCON at &FE34 SHALL work as follows: prv_s8 <= D4, prv_s4 <= D5, prv_s1 <= D6, sh_en <= D7.
REQ-017 WPIDX at &FE35 SHALL load the 2-bit index wp_idx <= DATA[1:0].
REQ-018 WPDATA at &FE36, when unlocked and wp_idx < NUM_BANKS/8, SHALL load wr_prot[8*wp_idx+7 : 8*wp_idx] <= DATA.
- Any write to WPDATA SHALL increment wp_idx modulo 4, whether or not the data is accepted.
REQ-019 A WPDATA write while locked, or with wp_idx out of range, SHALL leave wr_prot unchanged.
REQ-020 The unlock FSM on KEY at &FE32 SHALL have states LOCKED, KEY1 and UNLOCKED.
REQ-021 In LOCKED, a KEY write of &5A SHALL go to KEY1; any other value SHALL stay in LOCKED.
REQ-022 In KEY1, a KEY write of &A5 SHALL go to UNLOCKED and load tmo_cnt <= UNLOCK_TIMEOUT.
- Any other KEY value SHALL go to LOCKED.
- Non-KEY cycles SHALL hold KEY1.
REQ-023 In UNLOCKED, tmo_cnt SHALL decrement by 1 each edge.
- The FSM SHALL go to LOCKED at the edge where tmo_cnt = 1, or on any KEY write.
- A KEY write SHALL take priority over the timeout.
REQ-024 If a WPDATA write falls on the same edge as the timeout expiry, it SHALL be accepted, and LOCKED SHALL take effect from the next edge.
REQ-025 wp_locked SHALL be 0 only in UNLOCKED.
REQ-026 All outputs except cpu_dout and cpu_dout_oe SHALL be registered, so a write becomes visible one edge after the write cycle.

Reset
REQ-027 On bbc_RST=1 at an edge, the block SHALL set:
- rom_bank=0
- all six flags=0
- wp_idx=0
- wr_prot all 1s
- FSM=LOCKED, wp_locked=1
- tmo_cnt=0.
REQ-028 A reset mid-unlock, from KEY1 or UNLOCKED, SHALL abandon the sequence without altering wr_prot beyond the reset values.
REQ-029 A write cycle coincident with reset SHALL be ignored.

Configuration
REQ-030 Macro INTEGRAB_READBACK_EN SHALL control register readback.
- Defined: when from_CPU_RnW=1 and the address is &FE30, &FE34, &FE35 or &FE36, cpu_dout_oe=1 combinationally.
- cpu_dout SHALL then return, respectively: ROMSEL as written; ACCCON with bits [3:0]=0; {wp_locked, 5'b0, wp_idx}; and the selected wr_prot byte, or &00 if out of range.
- Undefined: cpu_dout=&00 and cpu_dout_oe=0 constantly, with no readback logic.

Verification
REQ-031 Reset, then write &FE30=&C5 with BANK_BITS=4 -> next edge rom_bank=5, prv_en=1, mem_sel=1; ACCCON flags unchanged at 0.
REQ-032 Locked, write &FE35=0 then &FE36=&00 -> wr_prot stays &FFFF, wp_idx=1, wp_locked=1.
REQ-033 Write &FE32=&5A, &FE32=&A5, &FE35=0, &FE36=&0F, &FE36=&F0 -> wr_prot=&F00F, wp_idx=2, wp_locked=0.
REQ-034 UNLOCK_TIMEOUT=4: unlock, then 4 idle cycles -> wp_locked=1 and a following &FE36 write is ignored; separately, &5A then &33 -> stays LOCKED.
REQ-035 BANK_BITS=5: unlock, then write WPDATA four times from idx 0 with &11,&22,&33,&44 -> wr_prot=&44332211, wp_idx wraps to 0.
REQ-036 INTEGRAB_READBACK_EN defined: after REQ-033, read &FE35 -> cpu_dout=&02, cpu_dout_oe=1; read &FE37 -> cpu_dout_oe=0. Undefined: every read gives cpu_dout_oe=0.

Source files
------------

// File: rtl/integrab_paging_unit_if.sv
// CPU bus bundle for the paging unit: write strobe, address, data and readback.
// Latency: none, this is a wiring bundle.
// Backpressure: none, the CPU bus is never stalled.
interface integrab_paging_unit_if;
  logic        from_CPU_RnW;
  logic [15:0] bbc_ADDRESS;
  logic [7:0]  bbc_DATA;
  logic [7:0]  cpu_dout;
  logic        cpu_dout_oe;

  modport master (
    output from_CPU_RnW, bbc_ADDRESS, bbc_DATA,
    input  cpu_dout, cpu_dout_oe
  );

  modport slave (
    input  from_CPU_RnW, bbc_ADDRESS, bbc_DATA,
    output cpu_dout, cpu_dout_oe
  );
endinterface

// File: rtl/integrab_paging_unit.sv
// Sideways ROM/RAM paging registers, ACCCON flags and keyed per-bank write protect.
// Latency: register writes become visible one edge after the write cycle; readback is combinational.
// Backpressure: none; every CPU cycle is accepted. INTEGRAB_READBACK_EN enables register readback.
module integrab_paging_unit #(
  parameter int BANK_BITS      = 4,
  parameter int UNLOCK_TIMEOUT = 255
) (
  input  logic                        from_CPU_Phi2,
  input  logic                        bbc_RST,
  integrab_paging_unit_if.slave       bus,
  output logic [BANK_BITS-1:0]        rom_bank,
  output logic                        prv_en,
  output logic                        mem_sel,
  output logic                        sh_en,
  output logic                        prv_s1,
  output logic                        prv_s4,
  output logic                        prv_s8,
  output logic [(1<<BANK_BITS)-1:0]   wr_prot,
  output logic                        wp_locked
);
  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int NUM_BYTES = NUM_BANKS / 8;

  localparam logic [15:0] ADDR_ROMSEL = 16'hFE30;
  localparam logic [15:0] ADDR_KEY    = 16'hFE32;
  localparam logic [15:0] ADDR_ACCCON = 16'hFE34;
  localparam logic [15:0] ADDR_WPIDX  = 16'hFE35;
  localparam logic [15:0] ADDR_WPDATA = 16'hFE36;

  localparam logic [7:0] KEY_FIRST  = 8'h5A;
  localparam logic [7:0] KEY_SECOND = 8'hA5;
  localparam logic [7:0] TMO_LOAD   = 8'(UNLOCK_TIMEOUT);

  typedef enum logic [1:0] {LOCKED, KEY1, UNLOCKED} lock_state_t;

  lock_state_t state;
  logic [7:0]  tmo_cnt;
  logic [1:0]  wp_idx;

  logic wr_cyc;
  logic wr_romsel;
  logic wr_key;
  logic wr_acccon;
  logic wr_wpidx;
  logic wr_wpdata;

  // Only a write cycle with an exact 16-bit address match touches a register.
  assign wr_cyc    = ~bus.from_CPU_RnW;
  assign wr_romsel = wr_cyc && (bus.bbc_ADDRESS == ADDR_ROMSEL);
  assign wr_key    = wr_cyc && (bus.bbc_ADDRESS == ADDR_KEY);
  assign wr_acccon = wr_cyc && (bus.bbc_ADDRESS == ADDR_ACCCON);
  assign wr_wpidx  = wr_cyc && (bus.bbc_ADDRESS == ADDR_WPIDX);
  assign wr_wpdata = wr_cyc && (bus.bbc_ADDRESS == ADDR_WPDATA);

  // ROMSEL and ACCCON control flags.
  always_ff @(posedge from_CPU_Phi2) begin
    if (bbc_RST) begin
      rom_bank <= '0;
      prv_en   <= 1'b0;
      mem_sel  <= 1'b0;
      sh_en    <= 1'b0;
      prv_s1   <= 1'b0;
      prv_s4   <= 1'b0;
      prv_s8   <= 1'b0;
    end else begin
      if (wr_romsel) begin
        rom_bank <= bus.bbc_DATA[BANK_BITS-1:0];
        prv_en   <= bus.bbc_DATA[6];
        mem_sel  <= bus.bbc_DATA[7];
      end
      if (wr_acccon) begin
        prv_s8 <= bus.bbc_DATA[4];
        prv_s4 <= bus.bbc_DATA[5];
        prv_s1 <= bus.bbc_DATA[6];
        sh_en  <= bus.bbc_DATA[7];
      end
    end
  end

  // Write-protect index and byte lanes; the index advances on every WPDATA write,
  // accepted or not, so software can stream bytes without reloading it.
  always_ff @(posedge from_CPU_Phi2) begin
    if (bbc_RST) begin
      wp_idx  <= 2'd0;
      wr_prot <= '1;
    end else if (wr_wpidx) begin
      wp_idx <= bus.bbc_DATA[1:0];
    end else if (wr_wpdata) begin
      wp_idx <= wp_idx + 2'd1;
      if (state == UNLOCKED) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (wp_idx == 2'(i)) begin
            wr_prot[8*i +: 8] <= bus.bbc_DATA;
          end
        end
      end
    end
  end

  // Unlock sequencer: 5A then A5 opens a timed window; any KEY write or expiry closes it.
  // A WPDATA write on the expiry edge still sees UNLOCKED and is accepted.
  always_ff @(posedge from_CPU_Phi2) begin
    if (bbc_RST) begin
      state     <= LOCKED;
      tmo_cnt   <= 8'd0;
      wp_locked <= 1'b1;
    end else begin
      case (state)
        LOCKED: begin
          if (wr_key && (bus.bbc_DATA == KEY_FIRST)) begin
            state <= KEY1;
          end
        end
        KEY1: begin
          if (wr_key) begin
            if (bus.bbc_DATA == KEY_SECOND) begin
              state     <= UNLOCKED;
              tmo_cnt   <= TMO_LOAD;
              wp_locked <= 1'b0;
            end else begin
              state <= LOCKED;
            end
          end
        end
        UNLOCKED: begin
          tmo_cnt <= tmo_cnt - 8'd1;
          if (wr_key || (tmo_cnt == 8'd1)) begin
            state     <= LOCKED;
            tmo_cnt   <= 8'd0;
            wp_locked <= 1'b1;
          end
        end
        default: begin
          state     <= LOCKED;
          tmo_cnt   <= 8'd0;
          wp_locked <= 1'b1;
        end
      endcase
    end
  end

`ifdef INTEGRAB_READBACK_EN
  logic [7:0] romsel_raw;

  // Full ROMSEL byte kept so readback returns exactly what software wrote.
  always_ff @(posedge from_CPU_Phi2) begin
    if (bbc_RST) begin
      romsel_raw <= 8'd0;
    end else if (wr_romsel) begin
      romsel_raw <= bus.bbc_DATA;
    end
  end

  // Combinational readback decode; out-of-range WPDATA bytes read as zero.
  always_comb begin
    bus.cpu_dout    = 8'd0;
    bus.cpu_dout_oe = 1'b0;
    if (bus.from_CPU_RnW) begin
      case (bus.bbc_ADDRESS)
        ADDR_ROMSEL: begin
          bus.cpu_dout_oe = 1'b1;
          bus.cpu_dout    = romsel_raw;
        end
        ADDR_ACCCON: begin
          bus.cpu_dout_oe = 1'b1;
          bus.cpu_dout    = {sh_en, prv_s1, prv_s4, prv_s8, 4'b0000};
        end
        ADDR_WPIDX: begin
          bus.cpu_dout_oe = 1'b1;
          bus.cpu_dout    = {wp_locked, 5'b00000, wp_idx};
        end
        ADDR_WPDATA: begin
          bus.cpu_dout_oe = 1'b1;
          for (int i = 0; i < NUM_BYTES; i++) begin
            if (wp_idx == 2'(i)) begin
              bus.cpu_dout = wr_prot[8*i +: 8];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end
`else
  assign bus.cpu_dout    = 8'd0;
  assign bus.cpu_dout_oe = 1'b0;
`endif

endmodule

// File: tb/tb_integrab_paging_unit.sv
// Bench for integrab_paging_unit: two instances (4-bit banks with a short unlock
// window, 5-bit banks with the default window) driven by the same CPU bus stimulus
// and compared every cycle against a byte-level behavioural model.
module tb_integrab_paging_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  integrab_paging_unit_if bus_a();
  integrab_paging_unit_if bus_b();

  logic [3:0]  bank_a;
  logic [15:0] wp_a;
  logic        prv_en_a, mem_sel_a, sh_en_a, prv_s1_a, prv_s4_a, prv_s8_a, lk_a;
  logic [4:0]  bank_b;
  logic [31:0] wp_b;
  logic        prv_en_b, mem_sel_b, sh_en_b, prv_s1_b, prv_s4_b, prv_s8_b, lk_b;

  integrab_paging_unit #(.BANK_BITS(4), .UNLOCK_TIMEOUT(4)) dut_a (
    .from_CPU_Phi2(clk), .bbc_RST(rst), .bus(bus_a.slave),
    .rom_bank(bank_a), .prv_en(prv_en_a), .mem_sel(mem_sel_a), .sh_en(sh_en_a),
    .prv_s1(prv_s1_a), .prv_s4(prv_s4_a), .prv_s8(prv_s8_a),
    .wr_prot(wp_a), .wp_locked(lk_a)
  );

  integrab_paging_unit #(.BANK_BITS(5), .UNLOCK_TIMEOUT(255)) dut_b (
    .from_CPU_Phi2(clk), .bbc_RST(rst), .bus(bus_b.slave),
    .rom_bank(bank_b), .prv_en(prv_en_b), .mem_sel(mem_sel_b), .sh_en(sh_en_b),
    .prv_s1(prv_s1_b), .prv_s4(prv_s4_b), .prv_s8(prv_s8_b),
    .wr_prot(wp_b), .wp_locked(lk_b)
  );

  // Behavioural model: raw register bytes, and the unlock window as a count of
  // remaining open edges (0 = locked) plus a "first key seen" bit.
  logic [7:0]  m_romsel[2];
  logic [7:0]  m_acccon[2];
  logic [1:0]  m_idx[2];
  logic [31:0] m_wp[2];
  int          m_left[2];
  bit          m_key1[2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(int k, bit r, bit rnw, logic [15:0] a, logic [7:0] d);
    int nb8;
    int tmo;
    int nl;
    nb8 = (k == 0) ? 2 : 4;
    tmo = (k == 0) ? 4 : 255;
    if (r) begin
      m_romsel[k] = 8'h00;
      m_acccon[k] = 8'h00;
      m_idx[k]    = 2'd0;
      m_wp[k]     = 32'hFFFF_FFFF;
      m_left[k]   = 0;
      m_key1[k]   = 1'b0;
      return;
    end
    nl = (m_left[k] > 0) ? m_left[k] - 1 : 0;
    if (!rnw) begin
      case (a)
        16'hFE30: m_romsel[k] = d;
        16'hFE34: m_acccon[k] = {d[7:4], 4'h0};
        16'hFE35: m_idx[k] = d[1:0];
        16'hFE36: begin
          if (m_left[k] > 0 && int'(m_idx[k]) < nb8) m_wp[k][8*m_idx[k] +: 8] = d;
          m_idx[k] = 2'(m_idx[k] + 2'd1);
        end
        16'hFE32: begin
          if (m_left[k] > 0) nl = 0;
          else if (m_key1[k]) begin
            m_key1[k] = 1'b0;
            if (d == 8'hA5) nl = tmo;
          end else if (d == 8'h5A) m_key1[k] = 1'b1;
        end
        default: ;
      endcase
    end
    m_left[k] = nl;
  endtask

  task automatic check_read(int k, bit rnw, logic [15:0] a, logic [7:0] dout, logic oe);
`ifdef INTEGRAB_READBACK_EN
    logic       exp_oe;
    logic [7:0] exp_d;
    int         nb8;
    nb8    = (k == 0) ? 2 : 4;
    exp_oe = rnw && (a inside {16'hFE30, 16'hFE34, 16'hFE35, 16'hFE36});
    exp_d  = 8'h00;
    case (a)
      16'hFE30: exp_d = m_romsel[k];
      16'hFE34: exp_d = m_acccon[k];
      16'hFE35: exp_d = {(m_left[k] == 0), 5'b00000, m_idx[k]};
      16'hFE36: exp_d = (int'(m_idx[k]) < nb8) ? m_wp[k][8*m_idx[k] +: 8] : 8'h00;
      default: ;
    endcase
    chk($sformatf("rd_oe%0d@%h", k, a), 32'(oe), 32'(exp_oe));
    if (exp_oe) chk($sformatf("rd_dout%0d@%h", k, a), 32'(dout), 32'(exp_d));
`else
    chk($sformatf("rd_oe%0d@%h", k, a), 32'(oe), 32'(rnw & 1'b0));
    chk($sformatf("rd_dout%0d@%h", k, a), 32'(dout), 32'h0);
`endif
  endtask

  task automatic check_state(int k, logic [4:0] bank, logic [5:0] fl, logic [31:0] wp, logic lk);
    logic [31:0] wmask;
    logic [4:0]  bmask;
    wmask = (k == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    bmask = (k == 0) ? 5'h0F : 5'h1F;
    chk($sformatf("bank%0d", k), 32'(bank), 32'(m_romsel[k][4:0] & bmask));
    chk($sformatf("flags%0d", k), 32'(fl),
        32'({m_romsel[k][7], m_romsel[k][6], m_acccon[k][7:4]}));
    chk($sformatf("wr_prot%0d", k), wp, m_wp[k] & wmask);
    chk($sformatf("locked%0d", k), 32'(lk), 32'(m_left[k] == 0));
  endtask

  task automatic drive(bit rnw, logic [15:0] a, logic [7:0] d);
    bus_a.from_CPU_RnW = rnw; bus_a.bbc_ADDRESS = a; bus_a.bbc_DATA = d;
    bus_b.from_CPU_RnW = rnw; bus_b.bbc_ADDRESS = a; bus_b.bbc_DATA = d;
  endtask

  // One CPU bus cycle: drive, check readback against pre-edge state, clock,
  // advance the model, then check registered outputs on the falling edge.
  task automatic cyc(bit r, bit rnw, logic [15:0] a, logic [7:0] d);
    rst = r;
    drive(rnw, a, d);
    #1;
    check_read(0, rnw, a, bus_a.cpu_dout, bus_a.cpu_dout_oe);
    check_read(1, rnw, a, bus_b.cpu_dout, bus_b.cpu_dout_oe);
    @(posedge clk);
    model_step(0, r, rnw, a, d);
    model_step(1, r, rnw, a, d);
    @(negedge clk);
    check_state(0, {1'b0, bank_a}, {mem_sel_a, prv_en_a, sh_en_a, prv_s1_a, prv_s4_a, prv_s8_a},
                {16'h0, wp_a}, lk_a);
    check_state(1, bank_b, {mem_sel_b, prv_en_b, sh_en_b, prv_s1_b, prv_s4_b, prv_s8_b},
                wp_b, lk_b);
  endtask

  task automatic wr(logic [15:0] a, logic [7:0] d); cyc(1'b0, 1'b0, a, d); endtask
  task automatic idle(); cyc(1'b0, 1'b1, 16'h0000, 8'h00); endtask

  // Present a read without clocking, for direct readback checks.
  task automatic peek(logic [15:0] a);
    drive(1'b1, a, 8'h00);
    #1;
  endtask

  logic [15:0] ra;
  logic [7:0]  rd;
  bit          rrnw;
  bit          rrst;
  int          sel;

  initial begin
    drive(1'b1, 16'h0000, 8'h00);
    @(negedge clk);

    // Reset, with writes coincident with reset that must be ignored.
    cyc(1'b1, 1'b0, 16'hFE30, 8'hFF);
    cyc(1'b1, 1'b0, 16'hFE36, 8'h00);
    chk("rst_bank", 32'(bank_a), 32'h0);
    chk("rst_wp", 32'(wp_a), 32'hFFFF);
    chk("rst_lk", 32'(lk_a), 32'h1);

    // ROMSEL: bank and top two flags, ACCCON untouched.
    wr(16'hFE30, 8'hC5);
    chk("romsel_bank", 32'(bank_a), 32'h5);
    chk("romsel_prv_en", 32'(prv_en_a), 32'h1);
    chk("romsel_mem_sel", 32'(mem_sel_a), 32'h1);
    chk("romsel_sh_en", 32'(sh_en_a), 32'h0);
    wr(16'hFE34, 8'hA0);

    // Locked WPDATA write is dropped but still advances the index.
    wr(16'hFE35, 8'h00);
    wr(16'hFE36, 8'h00);
    chk("locked_wp", 32'(wp_a), 32'hFFFF);
    chk("locked_lk", 32'(lk_a), 32'h1);
    peek(16'hFE35);
`ifdef INTEGRAB_READBACK_EN
    chk("locked_idx_rd", 32'(bus_a.cpu_dout), 32'h81);
`else
    chk("locked_idx_oe", 32'(bus_a.cpu_dout_oe), 32'h0);
`endif

    // Unlock and program two bytes.
    wr(16'hFE32, 8'h5A);
    wr(16'hFE32, 8'hA5);
    wr(16'hFE35, 8'h00);
    wr(16'hFE36, 8'h0F);
    wr(16'hFE36, 8'hF0);
    chk("unlock_wp", 32'(wp_a), 32'hF00F);
    chk("unlock_lk", 32'(lk_a), 32'h0);
    peek(16'hFE35);
`ifdef INTEGRAB_READBACK_EN
    chk("idx_rd", 32'(bus_a.cpu_dout), 32'h02);
    chk("idx_oe", 32'(bus_a.cpu_dout_oe), 32'h1);
`else
    chk("idx_oe", 32'(bus_a.cpu_dout_oe), 32'h0);
`endif
    peek(16'hFE37);
    chk("fe37_oe", 32'(bus_a.cpu_dout_oe), 32'h0);
    cyc(1'b0, 1'b1, 16'hFE35, 8'h00);

    // Timeout of 4 edges closes the window; later writes are ignored.
    wr(16'hFE32, 8'h5A);
    wr(16'hFE32, 8'hA5);
    idle(); idle(); idle();
    chk("tmo_open", 32'(lk_a), 32'h0);
    idle();
    chk("tmo_closed", 32'(lk_a), 32'h1);
    wr(16'hFE35, 8'h00);
    wr(16'hFE36, 8'h00);
    chk("tmo_wp", 32'(wp_a), 32'hF00F);

    // Wrong second key returns to LOCKED; a lone A5 does not unlock.
    wr(16'hFE32, 8'h5A);
    wr(16'hFE32, 8'h33);
    chk("badkey_lk", 32'(lk_a), 32'h1);
    wr(16'hFE32, 8'hA5);
    chk("lone_a5_lk", 32'(lk_a), 32'h1);

    // WPDATA on the expiry edge is still accepted.
    wr(16'hFE32, 8'h5A);
    wr(16'hFE32, 8'hA5);
    wr(16'hFE35, 8'h00);
    idle(); idle();
    wr(16'hFE36, 8'h3C);
    chk("expiry_wp", 32'(wp_a), 32'hF03C);
    chk("expiry_lk", 32'(lk_a), 32'h1);

    // Four bytes on the 32-bank instance, index wraps.
    cyc(1'b1, 1'b1, 16'h0000, 8'h00);
    wr(16'hFE32, 8'h5A);
    wr(16'hFE32, 8'hA5);
    wr(16'hFE35, 8'h00);
    wr(16'hFE36, 8'h11);
    wr(16'hFE36, 8'h22);
    wr(16'hFE36, 8'h33);
    wr(16'hFE36, 8'h44);
    chk("b32_wp", wp_b, 32'h4433_2211);
    chk("b32_lk", 32'(lk_b), 32'h0);
    peek(16'hFE35);
`ifdef INTEGRAB_READBACK_EN
    chk("b32_idx_rd", 32'(bus_b.cpu_dout), 32'h00);
`else
    chk("b32_idx_oe", 32'(bus_b.cpu_dout_oe), 32'h0);
`endif

    // Randomised register traffic, biased toward key and write-protect accesses.
    for (int n = 0; n < 1500; n++) begin
      sel = int'($urandom_range(0, 11));
      case (sel)
        0:       ra = 16'hFE30;
        1, 2, 3: ra = 16'hFE32;
        4:       ra = 16'hFE34;
        5:       ra = 16'hFE35;
        6, 7, 8: ra = 16'hFE36;
        9:       ra = ($urandom_range(0, 1) == 0) ? 16'hFE31 : 16'hFE37;
        10:      ra = 16'(32'hFE00 | $urandom_range(0, 255));
        default: ra = 16'($urandom);
      endcase
      rd = 8'($urandom);
      if (ra == 16'hFE32) begin
        case ($urandom_range(0, 2))
          0:       rd = 8'h5A;
          1:       rd = 8'hA5;
          default: ;
        endcase
      end
      rrnw = ($urandom_range(0, 3) == 0);
      rrst = ($urandom_range(0, 149) == 0);
      cyc(rrst, rrnw, ra, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
